// File: rtl/v_pkg.sv
// Shared types and constants for the CARRD vector issue sequencer.
// Holds the FSM state encoding, the functional-unit index map, the
// watchdog limit and a one-hot test used on the decoder's unit select.
package v_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_COMMIT = 3'd4
  } vseq_state_t;

  localparam int FU_ALU   = 0;
  localparam int FU_MUL   = 1;
  localparam int FU_RED   = 2;
  localparam int FU_SLDU  = 3;
  localparam int FU_LOAD  = 4;
  localparam int FU_STORE = 5;

  localparam logic [15:0] VSEQ_TIMEOUT = 16'hFFFF;

  // True when exactly one bit of v is set (callers zero-extend narrower selects).
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/carrd_vseq_fifo.sv
// Circular instruction buffer for the issue sequencer.
// Pointers wrap modulo DEPTH (power of two). A push while full and a pop
// while empty are both ignored; push and pop together keep count unchanged.
module carrd_vseq_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    wr_q;
  logic [CW-1:0]    cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && (cnt_q != CW'(DEPTH));
  assign pop_ok  = pop_i && (cnt_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/carrd_vseq.sv
// In-order issue sequencer for the CARRD vector coprocessor.
// Buffers instructions, holds one stable for decode, starts the selected
// unit, waits for its done pulse and pulses commit.
// Optional feature macro: CARRD_VSEQ_TIMEOUT_EN enables a 16-bit WAIT
// watchdog that sets a sticky timeout_err and forces the commit.
module carrd_vseq
  import v_pkg::*;
#(
  parameter  int NUM_FU = 6,
  parameter  int QDEPTH = 4,
  localparam int CW     = $clog2(QDEPTH + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr_in,
  output logic [31:0]       issue_instr,
  output logic              issue_valid,
  input  logic [NUM_FU-1:0] dec_fu_sel,
  input  logic              dec_is_vconfig,
  output logic [NUM_FU-1:0] fu_start,
  input  logic [NUM_FU-1:0] fu_done,
  output logic              vconfig_wr_en,
  output logic              commit,
  output logic              busy,
  output logic [CW-1:0]     q_count,
  output logic [31:0]       retired,
  output logic              illegal,
  output logic              timeout_err
);

  vseq_state_t       state_q;
  logic [31:0]       issue_instr_q;
  logic              issue_valid_q;
  logic [NUM_FU-1:0] sel_q;
  logic [NUM_FU-1:0] fu_start_q;
  logic              vconfig_wr_en_q;
  logic              commit_q;
  logic              illegal_q;
  logic [31:0]       retired_q;
  logic [31:0]       head_s;
  logic              push_s;
  logic              pop_s;
  logic              done_hit_s;
  logic              wdog_fire_s;

  assign instr_ready = (q_count < CW'(QDEPTH));
  assign push_s      = instr_valid && instr_ready;
  // The head is consumed whenever the FSM is free to load a new instruction.
  assign pop_s       = ((state_q == ST_IDLE) || (state_q == ST_COMMIT)) && (q_count != '0);
  assign done_hit_s  = ((fu_done & sel_q) != '0);

  carrd_vseq_fifo #(.WIDTH(32), .DEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (instr_in),
    .head_o  (head_s),
    .count_o (q_count)
  );

`ifdef CARRD_VSEQ_TIMEOUT_EN
  logic [15:0] wdog_q;
  logic        timeout_err_q;

  assign wdog_fire_s = (state_q == ST_WAIT) && !done_hit_s && (wdog_q == VSEQ_TIMEOUT);
  assign timeout_err = timeout_err_q;

  // Watchdog: cleared in START, counts WAIT cycles, sticky error on expiry.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wdog_q        <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == ST_START) begin
        wdog_q <= 16'd0;
      end else if (state_q == ST_WAIT) begin
        wdog_q <= wdog_q + 16'd1;
      end else begin
        wdog_q <= wdog_q;
      end
      if (wdog_fire_s) begin
        timeout_err_q <= 1'b1;
      end
    end
  end
`else
  assign wdog_fire_s = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Issue FSM with registered handshake pulses and retire counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q         <= ST_IDLE;
      issue_instr_q   <= 32'd0;
      issue_valid_q   <= 1'b0;
      sel_q           <= '0;
      fu_start_q      <= '0;
      vconfig_wr_en_q <= 1'b0;
      commit_q        <= 1'b0;
      illegal_q       <= 1'b0;
      retired_q       <= 32'd0;
    end else begin
      fu_start_q      <= '0;
      vconfig_wr_en_q <= 1'b0;
      commit_q        <= 1'b0;
      illegal_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop_s) begin
            issue_instr_q <= head_s;
            issue_valid_q <= 1'b1;
            state_q       <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          // vconfig takes priority; otherwise only a one-hot select is issuable.
          if (dec_is_vconfig) begin
            vconfig_wr_en_q <= 1'b1;
            commit_q        <= 1'b1;
            retired_q       <= retired_q + 32'd1;
            state_q         <= ST_COMMIT;
          end else if (is_onehot(32'(dec_fu_sel))) begin
            sel_q      <= dec_fu_sel;
            fu_start_q <= dec_fu_sel;
            state_q    <= ST_START;
          end else begin
            illegal_q <= 1'b1;
            commit_q  <= 1'b1;
            retired_q <= retired_q + 32'd1;
            state_q   <= ST_COMMIT;
          end
        end
        ST_START: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_hit_s || wdog_fire_s) begin
            commit_q  <= 1'b1;
            retired_q <= retired_q + 32'd1;
            state_q   <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          if (pop_s) begin
            issue_instr_q <= head_s;
            state_q       <= ST_DECODE;
          end else begin
            issue_valid_q <= 1'b0;
            state_q       <= ST_IDLE;
          end
        end
        default: begin
          issue_valid_q <= 1'b0;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

  assign issue_instr   = issue_instr_q;
  assign issue_valid   = issue_valid_q;
  assign fu_start      = fu_start_q;
  assign vconfig_wr_en = vconfig_wr_en_q;
  assign commit        = commit_q;
  assign illegal       = illegal_q;
  assign retired       = retired_q;
  assign busy          = (state_q != ST_IDLE) || (q_count != '0);

endmodule
